// File: rtl/bcd_fib_pkg.sv
// Shared types and constant helpers for the BCD Fibonacci engine.
package bcd_fib_pkg;

    // Top-level sequencing states
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CONV = 3'd1,
        FIB  = 3'd2,
        B2B  = 3'd3,
        DONE = 3'd4
    } state_t;

    // 10**k, used for sizing the index register and the result limit
    function automatic logic [63:0] pow10(input int k);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < k; i++) r = r * 64'd10;
        return r;
    endfunction

    // Bits needed to encode x distinct values (ceil(log2(x)))
    function automatic int clog2(input logic [63:0] x);
        int          r;
        logic [63:0] v;
        r = 0;
        v = x - 64'd1;
        for (int i = 0; i < 64; i++) begin
            if (v != 64'd0) begin
                r = r + 1;
                v = v >> 1;
            end
        end
        return r;
    endfunction

    // Saturation pattern: 'digits' nibbles of 4'h9, right aligned
    function automatic logic [31:0] nines(input int digits);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < digits; i++) r[4*i +: 4] = 4'h9;
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd_dd.sv
// Sequential double-dabble converter: BIN_W cycles after start, done is high
// for one cycle and bcd carries the completed result in that same cycle.
module bin2bcd_dd
    import bcd_fib_pkg::*;
#(
    parameter int BIN_W  = 20,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int CNT_W = clog2(64'(BIN_W) + 64'd1);

    logic                 busy;
    logic [CNT_W-1:0]     cnt;
    logic [BIN_W-1:0]     bin_sr;
    logic [4*DIGITS-1:0]  bcd_sr;
    logic [4*DIGITS-1:0]  bcd_adj;

    // Add 3 to every digit that would reach 10 or more after doubling
    always_comb begin
        bcd_adj = bcd_sr;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_sr[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_sr[4*i +: 4] + 4'd3;
        end
    end

    // The shifted value is exposed directly so the last step's result is
    // usable in the same cycle done is raised, without an extra register stage.
    assign bcd  = (bcd_adj << 1) | {{(4*DIGITS-1){1'b0}}, bin_sr[BIN_W-1]};
    assign done = busy && (cnt == CNT_W'(BIN_W - 1));

    // One adjust+shift step per cycle while busy
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            busy   <= 1'b0;
            cnt    <= '0;
            bin_sr <= '0;
            bcd_sr <= '0;
        end else if (start) begin
            busy   <= 1'b1;
            cnt    <= '0;
            bin_sr <= bin;
            bcd_sr <= '0;
        end else if (busy) begin
            bcd_sr <= bcd;
            bin_sr <= bin_sr << 1;
            cnt    <= cnt + CNT_W'(1);
            if (done) busy <= 1'b0;
        end
    end

endmodule

// File: rtl/bcd_fib_param.sv
// BCD-in / BCD-out Fibonacci engine: converts a BCD index to binary, iterates
// fib, then converts the binary result back to BCD with double-dabble.
module bcd_fib_param
    import bcd_fib_pkg::*;
#(
    parameter int IN_DIGITS  = 2,
    parameter int OUT_DIGITS = 4,
    parameter int FIB_W      = 20,
    parameter int MAX_IDX    = 30
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [4*IN_DIGITS-1:0]  bcd_in,
    output logic                    ready,
    output logic                    done_tick,
    output logic [4*OUT_DIGITS-1:0] bcd_out,
    output logic                    overflow,
    output logic                    bcd_err
);

    localparam int          IDX_W     = clog2(pow10(IN_DIGITS));
    localparam int          MUL_W     = IDX_W + 4;
    localparam int          DIG_W     = clog2(64'(IN_DIGITS) + 64'd1);
    localparam logic [63:0] OUT_LIMIT = pow10(OUT_DIGITS);
    localparam logic [31:0] NINES_ALL = nines(OUT_DIGITS);
    localparam logic [4*OUT_DIGITS-1:0] NINES = NINES_ALL[4*OUT_DIGITS-1:0];

    state_t                 state;
    logic [4*IN_DIGITS-1:0] bcd_lat;
    logic [IDX_W-1:0]       idx;
    logic [IDX_W-1:0]       cnt;
    logic [DIG_W-1:0]       dig_cnt;
    logic                   err;
    logic [FIB_W-1:0]       t0;
    logic [FIB_W-1:0]       t1;

    logic [3:0]             cur_digit;
    logic                   fib_ovf;
    logic                   dd_start;
    logic                   dd_done;
    logic [4*OUT_DIGITS-1:0] dd_bcd;

    // Latched index is consumed MSD first by shifting it left one digit per cycle
    assign cur_digit = bcd_lat[4*IN_DIGITS-1 -: 4];
    assign fib_ovf   = 64'(t0) >= OUT_LIMIT;
    // Converter is kicked in the same cycle FIB finishes so B2B is exactly FIB_W cycles
    assign dd_start  = (state == FIB) && (cnt == '0) && !fib_ovf;

    bin2bcd_dd #(
        .BIN_W  (FIB_W),
        .DIGITS (OUT_DIGITS)
    ) u_dd (
        .clk   (clk),
        .reset (reset),
        .start (dd_start),
        .bin   (t0),
        .done  (dd_done),
        .bcd   (dd_bcd)
    );

    // Main sequencer with registered handshake and result outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            ready     <= 1'b1;
            done_tick <= 1'b0;
            bcd_out   <= '0;
            overflow  <= 1'b0;
            bcd_err   <= 1'b0;
            bcd_lat   <= '0;
            idx       <= '0;
            cnt       <= '0;
            dig_cnt   <= '0;
            err       <= 1'b0;
            t0        <= '0;
            t1        <= '0;
        end else begin
            done_tick <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        bcd_lat <= bcd_in;
                        idx     <= '0;
                        dig_cnt <= '0;
                        err     <= 1'b0;
                        ready   <= 1'b0;
                        state   <= CONV;
                    end
                end
                CONV: begin
                    if (dig_cnt != DIG_W'(IN_DIGITS)) begin
                        if (cur_digit > 4'd9) err <= 1'b1;
                        idx     <= IDX_W'(MUL_W'(idx) * MUL_W'(10) + MUL_W'(cur_digit));
                        bcd_lat <= bcd_lat << 4;
                        dig_cnt <= dig_cnt + DIG_W'(1);
                    end else if (err) begin
                        bcd_out   <= NINES;
                        overflow  <= 1'b0;
                        bcd_err   <= 1'b1;
                        done_tick <= 1'b1;
                        state     <= DONE;
                    end else if (32'(idx) > MAX_IDX) begin
                        bcd_out   <= NINES;
                        overflow  <= 1'b1;
                        bcd_err   <= 1'b0;
                        done_tick <= 1'b1;
                        state     <= DONE;
                    end else begin
                        t0    <= '0;
                        t1    <= FIB_W'(1);
                        cnt   <= idx;
                        state <= FIB;
                    end
                end
                FIB: begin
                    if (cnt == '0) begin
                        if (fib_ovf) begin
                            bcd_out   <= NINES;
                            overflow  <= 1'b1;
                            bcd_err   <= 1'b0;
                            done_tick <= 1'b1;
                            state     <= DONE;
                        end else begin
                            state <= B2B;
                        end
                    end else begin
                        t0  <= t1;
                        t1  <= t0 + t1;
                        cnt <= cnt - IDX_W'(1);
                    end
                end
                B2B: begin
                    if (dd_done) begin
                        bcd_out   <= dd_bcd;
                        overflow  <= 1'b0;
                        bcd_err   <= 1'b0;
                        done_tick <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
